quotient_bcd_converter: RTL and testbench

Sequential double-dabble converter that sits directly downstream of the unsigned divider. It captures one divider result (quotient plus remainder) through a valid/ready handshake and converts the quotient to packed BCD, one binary bit per clock. It presents the digits, a significant-digit count and the untouched remainder to the display/report stage. One conversion is in flight at a time.

---
 rtl/div_pkg.sv | 13 +
 rtl/bcd_add3_digit.sv | 7 +
 rtl/quotient_bcd_converter.sv | 82 ++++++++
 tb/tb_quotient_bcd_converter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the divider and its downstream
// quotient-to-BCD converter.
package div_pkg;
  localparam int N_DEF      = 32;
  localparam int DIGITS_DEF = 10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Width of a field that counts 0..digits
  function automatic int ndig_w(input int digits);
    return $clog2(digits + 1);
  endfunction
endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/quotient_bcd_converter.sv
// Sequential double-dabble: accepts one quotient/remainder pair and converts
// the quotient to packed BCD one bit per clock; the remainder passes through.
module quotient_bcd_converter
  import div_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0]                  quotient,
  input  logic [N-1:0]                  remainder,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*DIGITS-1:0]           bcd,
  output logic [ndig_w(DIGITS)-1:0]     ndigits,
  output logic [N-1:0]                  rem_out
);
  localparam int CW  = $clog2(N + 1);
  localparam int NDW = ndig_w(DIGITS);

  state_t              state, state_nx;
  logic [N-1:0]        bin;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (.d(bcd[4*g +: 4]), .q(adj[4*g +: 4]));
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid)               state_nx = SHIFT;
      SHIFT: if (cnt == CW'(N - 1))      state_nx = DONE;
      DONE:  if (out_ready)              state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Add-3 happens on the current digits, then the whole {bcd, bin} shifts left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      rem_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          bin     <= quotient;
          rem_out <= remainder;
          bcd     <= '0;
          cnt     <= '0;
        end
        SHIFT: begin
          bcd <= {adj[4*DIGITS-2:0], bin[N-1]};
          bin <= {bin[N-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Highest nonzero digit wins; an all-zero value still reports one digit.
  always_comb begin
    ndigits = NDW'(1);
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) ndigits = NDW'(i + 1);
  end
endmodule

// File: tb/tb_quotient_bcd_converter.sv
// Self-checking bench for quotient_bcd_converter: directed table, backpressure,
// mid-conversion reset and randomized values against a decimal model.
module tb_quotient_bcd_converter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] quotient = '0;
  logic [31:0] remainder = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] bcd;
  logic [3:0]  ndigits;
  logic [31:0] rem_out;

  int checks = 0;
  int errors = 0;

  quotient_bcd_converter #(.N(32), .DIGITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .remainder(remainder), .out_valid(out_valid),
    .out_ready(out_ready), .bcd(bcd), .ndigits(ndigits), .rem_out(rem_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [39:0] bcd;
    logic [3:0]  nd;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Decimal reference: repeated division by ten.
  function automatic logic [39:0] ref_bcd(input logic [31:0] q);
    longint unsigned v = q;
    logic [39:0] res = '0;
    for (int i = 0; i < 10; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  function automatic logic [3:0] ref_nd(input logic [31:0] q);
    longint unsigned v = q;
    int c = 0;
    while (v > 0) begin
      c++;
      v = v / 10;
    end
    return (c == 0) ? 4'd1 : 4'(c);
  endfunction

  task automatic accept(input logic [31:0] q, input logic [31:0] r);
    int n = 0;
    @(negedge clk);
    quotient = q; remainder = r; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(in_ready, "accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    quotient = $urandom; remainder = $urandom;
  endtask

  // Call right after the accept edge: checks latency, results, then handshakes.
  task automatic wait_done(input logic [39:0] eb, input logic [3:0] en, input logic [31:0] er, input string nm);
    int cyc = 0;
    bit dig_ok = 1'b1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(cyc == 32, {nm, "_latency"}, 64'(cyc), 64'd32);
    chk(bcd == eb, {nm, "_bcd"}, 64'(bcd), 64'(eb));
    chk(ndigits == en, {nm, "_ndigits"}, 64'(ndigits), 64'(en));
    chk(rem_out == er, {nm, "_rem"}, 64'(rem_out), 64'(er));
    for (int i = 0; i < 10; i++) if (bcd[4*i +: 4] > 4'd9) dig_ok = 1'b0;
    chk(dig_ok, {nm, "_digit_le9"}, 64'(bcd), 64'(eb));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk(!out_valid && in_ready, {nm, "_handshake"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    tbl[0] = '{32'd4,          32'd2, 40'h4,          4'd1};
    tbl[1] = '{32'd333,        32'd0, 40'h333,        4'd3};
    tbl[2] = '{32'd1000,       32'd1, 40'h1000,       4'd4};
    tbl[3] = '{32'd0,          32'd7, 40'h0,          4'd1};
    tbl[4] = '{32'hFFFF_FFFF,  32'd9, 40'h4294967295, 4'd10};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    chk(bcd == '0, "rst_bcd", 64'(bcd), 64'd0);
    chk(ndigits == 4'd1, "rst_ndigits", 64'(ndigits), 64'd1);
    chk(rem_out == '0, "rst_rem", 64'(rem_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(in_ready == 1'b1, "post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      accept(tbl[i].q, tbl[i].r);
      wait_done(tbl[i].bcd, tbl[i].nd, tbl[i].r, $sformatf("tbl%0d", i));
    end

    // Backpressure: results held while upstream changes inputs and holds valid
    begin
      bit stable = 1'b1;
      accept(32'd98765, 32'd11);
      for (int c = 0; c < 100 && !out_valid; c++) begin
        @(posedge clk);
        #1;
      end
      chk(out_valid, "bp_done", 64'(out_valid), 64'd1);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        in_valid = 1'b1; quotient = 32'd42 + 32'(c); remainder = 32'd5;
        if (!out_valid || in_ready || bcd != 40'h98765 || ndigits != 4'd5 || rem_out != 32'd11)
          stable = 1'b0;
      end
      chk(stable, "bp_stable", 64'(bcd), 64'h98765);
      @(negedge clk);
      quotient = 32'd123; remainder = 32'd3;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk(!out_valid && in_ready, "bp_release", 64'({out_valid, in_ready}), 64'b01);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      quotient = 32'd777;
      chk(!in_ready, "bp_next_accepted", 64'(in_ready), 64'd0);
      wait_done(40'h123, 4'd3, 32'd3, "bp_next");
    end

    // Reset mid-SHIFT: nothing partial may be flagged valid
    begin
      bit never = 1'b1;
      accept(32'd55555, 32'd1);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk(!out_valid && in_ready && bcd == '0 && rem_out == '0, "midrst_clear",
          64'(bcd), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (out_valid) never = 1'b0;
      end
      chk(never, "midrst_no_valid", 64'(out_valid), 64'd0);
    end

    // Randomized against the decimal model
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] q, r;
      q = $urandom >> $urandom_range(0, 31);
      r = $urandom;
      accept(q, r);
      wait_done(ref_bcd(q), ref_nd(q), r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
